dft4_frame_ctrl: RTL and testbench
==================================

# dft4_frame_ctrl

Frame controller that sequences the shared 4-point DFT engine (`dft4point`). It collects a serial 16-bit sample stream into 4-sample frames and drives the engine's operands and start strobe. It captures the 4 complex bins and streams them out one bin per transfer under valid/ready backpressure. It sits between the sample source and the spectral consumer, and is the only block that drives the engine.

## Interface
- `ENG_LAT`, default 2: number of cycles `eng_start` is held high with stable operands. Must be ≥2.
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `s_valid`  in  1  input sample valid.
- `s_ready`  out  1  input sample ready.
- `s_data`  in  16  signed input sample.
- `m_valid`  out  1  output bin valid.
- `m_ready`  in  1  output bin ready.
- `m_re`, `m_im`  out  16 each  signed bin real and imaginary parts.
- `m_bin`  out  2  bin index k.
- `m_last`  out  1  high with bin 3.
- `eng_start`  out  1  engine start strobe.
- `eng_x0`..`eng_x3`  out  16 each  engine operands.
- `eng_xr0`..`eng_xr3`, `eng_xi0`..`eng_xi3`  in  16 each  engine results.
- `busy`  out  1  `state != IDLE` or `in_cnt != 0`.
- `frame_cnt`  out  16  completed output frames, modulo 2^16.

## Operation
- **Input collector**
  - 3-bit `in_cnt` (0..4) and a 4-entry operand buffer that drives `eng_x0..3` directly.
  - `s_ready = (in_cnt != 4)`. This is combinational from a register.
  - Accept on `s_valid && s_ready`: write sample to entry `in_cnt`, then increment. The first accepted sample of a frame is x0.
  - The collector runs independently of the FSM, so the next frame may fill while the previous one drains.
- **FSM states:** IDLE, RUN, CAPT, DRAIN.
  - IDLE → RUN when registered `in_cnt == 4`.
  - RUN: `eng_start = 1`, 2-bit `run_cnt` counts up. Leave to CAPT after ENG_LAT cycles in RUN. The operand buffer cannot change here because it is full.
  - CAPT: `eng_start = 0`. At the closing edge, register `eng_xr*`/`eng_xi*` into the result buffer, clear `in_cnt` to 0 (this overrides any accept; `s_ready` is 0 anyway), set `bin = 0`, then go to DRAIN.
  - DRAIN: `m_valid = 1`, and `m_re`/`m_im` = result[bin]. `m_bin = bin`, `m_last = (bin == 3)`.
    - On transfer with bin < 3: bin increments.
    - On transfer with bin == 3: `frame_cnt` increments (0xFFFF wraps to 0). Next state is RUN if registered `in_cnt == 4`, else IDLE.
- **Engine timing:** the engine's done flag is sticky, so the controller times the engine purely by cycle count and ignores done.
- **Arithmetic:** no arithmetic on data. Results are passed through bit-exact. Scaling belongs to the engine.
- **Reset** (`reset_n` low at a rising edge) puts everything in IDLE:
  - `in_cnt`, operand buffer, result buffer, `bin`, `run_cnt`, `frame_cnt` = 0.
  - After reset: `s_ready = 1`, and `m_valid`, `m_last`, `eng_start`, `busy` = 0. `m_re`, `m_im`, `m_bin`, `eng_x*` = 0.
  - Reset mid-frame or mid-drain discards all partial data. No bins are emitted for that frame.

## Timing
- All outputs are registered state or simple decode of registered state. There is no combinational path from `s_valid` or `m_ready` to any output.
- **Latency:** let E be the edge that accepts sample 4.
  - RUN is entered at E+1.
  - CAPT is entered at E+1+ENG_LAT.
  - `m_valid` with bin 0 is first high after edge E+2+ENG_LAT. With the default, that is 4 edges after E.
- **Throughput:** with `m_ready` held high, DRAIN lasts 4 cycles. A frame already full at the last transfer goes straight to RUN, giving a steady-state frame period of ENG_LAT+5 cycles.
- **Simultaneous 4th accept and bin-3 transfer:** `in_cnt` becomes 4 one edge after the FSM decision, so the FSM goes to IDLE. It then goes to RUN on the next edge, one cycle later than the already-full case. This behaviour is required.
- **Backpressure:** `m_valid` and all `m_*` stay stable while `m_ready` is low.
- **Input stalls:** gaps in `s_valid` are allowed anywhere and do not affect the FSM.

## Test plan
- Reset then samples 1, 2, 3, 4 back-to-back, `m_ready = 1`, ENG_LAT = 2:
  - `eng_start` high for exactly 2 cycles.
  - Bins k = 0..3 emitted in order with (re, im) = (10, 0), (−2, 2), (−2, 0), (−2, −2).
  - `m_last` high on k = 3 only. `frame_cnt` = 1.
  - First `m_valid` 4 edges after the 4th accept.
- Hold `m_ready` low for 10 cycles during DRAIN while streaming the next frame:
  - Outputs stay stable.
  - `s_ready` drops after 4 accepts.
  - The second frame enters RUN the cycle after the first frame's bin-3 transfer.
- Make the 4th accept coincide with the bin-3 transfer:
  - FSM goes IDLE for exactly 1 cycle, then RUN.
  - No sample is lost or duplicated.
- Assert `reset_n` low for 1 cycle in RUN, and separately after 2 DRAIN transfers:
  - All outputs return to reset values.
  - The next full frame produces correct bins with k restarting at 0.
- Run 65,537 frames (or force `frame_cnt` to 0xFFFF): `frame_cnt` wraps to 0 and then reads 1.
- Random `s_valid`/`m_ready` over 1,000 frames against a reference model: bit-exact bins in order, no drops.

Source files
------------

// File: rtl/dft4_frame_ctrl.sv
// ---------------------------------------------------------------------------
// dft4_frame_ctrl
//   Frame controller for the shared 4-point DFT engine. Gathers a serial
//   16-bit sample stream into 4-sample frames, drives the engine's operands
//   and start strobe for ENG_LAT cycles, captures the 4 complex bins and
//   streams them out one bin per valid/ready transfer.
//
// Parameters
//   ENG_LAT    cycles eng_start is held with stable operands (2..4; the
//              2-bit run counter bounds the upper end)
//
// Ports
//   clk, reset_n               clock, synchronous active-low reset
//   s_valid/s_ready/s_data     sample input stream
//   m_valid/m_ready            bin output handshake
//   m_re, m_im, m_bin, m_last  bin payload, index, last-of-frame flag
//   eng_start, eng_x0..3       engine start strobe and operands
//   eng_xr0..3, eng_xi0..3     engine results (real / imaginary)
//   busy                       FSM not idle or a frame is partially collected
//   frame_cnt                  completed output frames, modulo 2^16
// ---------------------------------------------------------------------------
module dft4_frame_ctrl #(
  parameter int ENG_LAT = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_re,
  output logic [15:0] m_im,
  output logic [1:0]  m_bin,
  output logic        m_last,
  output logic        eng_start,
  output logic [15:0] eng_x0,
  output logic [15:0] eng_x1,
  output logic [15:0] eng_x2,
  output logic [15:0] eng_x3,
  input  logic [15:0] eng_xr0,
  input  logic [15:0] eng_xr1,
  input  logic [15:0] eng_xr2,
  input  logic [15:0] eng_xr3,
  input  logic [15:0] eng_xi0,
  input  logic [15:0] eng_xi1,
  input  logic [15:0] eng_xi2,
  input  logic [15:0] eng_xi3,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, CAPT, DRAIN} state_t;

  localparam logic [1:0] RUN_LAST = 2'(ENG_LAT - 1);

  state_t      state, state_nx;
  logic [2:0]  in_cnt;
  logic [15:0] x_buf  [4];
  logic [15:0] re_buf [4];
  logic [15:0] im_buf [4];
  logic [1:0]  bin;
  logic [1:0]  run_cnt;

  logic in_full;
  logic accept;
  logic xfer;

  assign in_full = (in_cnt == 3'd4);
  assign accept  = s_valid && s_ready;
  assign xfer    = (state == DRAIN) && m_ready;

  // Every output is registered state or a decode of it; nothing here
  // depends combinationally on s_valid or m_ready.
  assign s_ready   = !in_full;
  assign eng_start = (state == RUN);
  assign m_valid   = (state == DRAIN);
  assign m_last    = (state == DRAIN) && (bin == 2'd3);
  assign m_bin     = bin;
  assign m_re      = re_buf[bin];
  assign m_im      = im_buf[bin];
  assign busy      = (state != IDLE) || (in_cnt != 3'd0);
  assign eng_x0    = x_buf[0];
  assign eng_x1    = x_buf[1];
  assign eng_x2    = x_buf[2];
  assign eng_x3    = x_buf[3];

  // The engine's done flag is sticky, so it is never consulted: the engine
  // is timed purely by counting ENG_LAT cycles in RUN.
  always_comb begin
    // NOTE: default first so every path assigns state_nx and no latch is inferred.
    state_nx = state;
    unique case (state)
      IDLE:    if (in_full) state_nx = RUN;
      RUN:     if (run_cnt == RUN_LAST) state_nx = CAPT;
      CAPT:    state_nx = DRAIN;
      DRAIN: begin
        // in_cnt is the registered count, so a 4th sample accepted on the
        // same edge as the bin-3 transfer is seen one cycle later (via IDLE).
        if (m_ready && bin == 2'd3) state_nx = in_full ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the buffers are reset explicitly because their contents are
      // visible on eng_x* and m_re/m_im straight out of reset.
      state     <= IDLE;
      in_cnt    <= 3'd0;
      bin       <= 2'd0;
      run_cnt   <= 2'd0;
      frame_cnt <= 16'd0;
      for (int i = 0; i < 4; i++) begin
        x_buf[i]  <= 16'd0;
        re_buf[i] <= 16'd0;
        im_buf[i] <= 16'd0;
      end
    end else begin
      // NOTE: non-blocking throughout so each register sees pre-edge values.
      state <= state_nx;

      // Collector runs alongside the FSM; CAPT frees the operand buffer and
      // takes priority (s_ready is already low then, the buffer being full).
      if (state == CAPT) begin
        in_cnt <= 3'd0;
      end else if (accept) begin
        x_buf[in_cnt[1:0]] <= s_data;
        in_cnt             <= in_cnt + 3'd1;
      end

      if (state == RUN) begin
        run_cnt <= (run_cnt == RUN_LAST) ? 2'd0 : run_cnt + 2'd1;
      end

      if (state == CAPT) begin
        re_buf[0] <= eng_xr0;
        re_buf[1] <= eng_xr1;
        re_buf[2] <= eng_xr2;
        re_buf[3] <= eng_xr3;
        im_buf[0] <= eng_xi0;
        im_buf[1] <= eng_xi1;
        im_buf[2] <= eng_xi2;
        im_buf[3] <= eng_xi3;
        bin       <= 2'd0;
      end

      if (xfer) begin
        if (bin != 2'd3) bin <= bin + 2'd1;
        else             frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dft4_frame_ctrl.sv
`timescale 1ns/1ps
module tb_dft4_frame_ctrl;

  localparam int ENG_LAT = 2;
  localparam logic [118:0] RESET_SNAP = {1'b1, 118'd0};

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
    logic [1:0]  k;
  } bin_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = 16'd0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_re, m_im;
  logic [1:0]  m_bin;
  logic        m_last;
  logic        eng_start;
  logic [15:0] eng_x0, eng_x1, eng_x2, eng_x3;
  logic [15:0] eng_xr0 = 0, eng_xr1 = 0, eng_xr2 = 0, eng_xr3 = 0;
  logic [15:0] eng_xi0 = 0, eng_xi1 = 0, eng_xi2 = 0, eng_xi3 = 0;
  logic        busy;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  dft4_frame_ctrl #(.ENG_LAT(ENG_LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_re(m_re), .m_im(m_im), .m_bin(m_bin), .m_last(m_last),
    .eng_start(eng_start),
    .eng_x0(eng_x0), .eng_x1(eng_x1), .eng_x2(eng_x2), .eng_x3(eng_x3),
    .eng_xr0(eng_xr0), .eng_xr1(eng_xr1), .eng_xr2(eng_xr2), .eng_xr3(eng_xr3),
    .eng_xi0(eng_xi0), .eng_xi1(eng_xi1), .eng_xi2(eng_xi2), .eng_xi3(eng_xi3),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [15:0] src_q[$];
  int          src_pct = 0;
  int          snk_pct = 0;
  bit          snk_hold = 1'b0;
  bit          acc_flag = 1'b0;
  bin_t        exp_q[$];
  int          e_q[$];
  logic [15:0] part [4];
  int          mic = 0;
  int          last_t3 = -1000;
  int          run_r = 0;
  int          st_len = 0;
  int          e_edge, want;
  bit          st_prev = 0, mv_prev = 0, hold_prev = 0;
  logic [15:0] h_re, h_im;
  logic [1:0]  h_bin;
  logic        h_last;
  logic [15:0] fc_model = 16'd0;
  int          xfer_n = 0, coinc_n = 0, full_n = 0;
  int          eng_cnt = 0;
  bin_t        got, b;

  // Reference 4-point DFT, X[k] = sum x[n] * exp(-j*2*pi*k*n/4), mod 2^16.
  function automatic bin_t dft4(input logic [15:0] a, input logic [15:0] bb,
                                input logic [15:0] c, input logic [15:0] d,
                                input int k);
    bin_t r;
    r.k = 2'(k);
    case (k)
      0:       begin r.re = a + bb + c + d; r.im = 16'd0;  end
      1:       begin r.re = a - c;          r.im = d - bb; end
      2:       begin r.re = a - bb + c - d; r.im = 16'd0;  end
      default: begin r.re = a - c;          r.im = bb - d; end
    endcase
    return r;
  endfunction

  function automatic logic [118:0] out_snap();
    return {s_ready, m_valid, m_last, eng_start, busy, m_re, m_im, m_bin,
            eng_x0, eng_x1, eng_x2, eng_x3, frame_cnt};
  endfunction

  always @(posedge clk) cyc++;

  // Engine model: junk while started, real results only once start has been
  // held exactly ENG_LAT cycles and dropped (i.e. during CAPT and after).
  always @(negedge clk) begin
    if (!reset_n) begin
      eng_cnt = 0;
    end else if (eng_start) begin
      eng_cnt++;
      if (eng_cnt == 1) begin
        eng_xr0 = 16'hDEAD; eng_xr1 = 16'hDEAD; eng_xr2 = 16'hDEAD; eng_xr3 = 16'hDEAD;
        eng_xi0 = 16'hBEEF; eng_xi1 = 16'hBEEF; eng_xi2 = 16'hBEEF; eng_xi3 = 16'hBEEF;
      end
    end else begin
      if (eng_cnt == ENG_LAT) begin
        got = dft4(eng_x0, eng_x1, eng_x2, eng_x3, 0); eng_xr0 = got.re; eng_xi0 = got.im;
        got = dft4(eng_x0, eng_x1, eng_x2, eng_x3, 1); eng_xr1 = got.re; eng_xi1 = got.im;
        got = dft4(eng_x0, eng_x1, eng_x2, eng_x3, 2); eng_xr2 = got.re; eng_xi2 = got.im;
        got = dft4(eng_x0, eng_x1, eng_x2, eng_x3, 3); eng_xr3 = got.re; eng_xi3 = got.im;
      end
      eng_cnt = 0;
    end
  end

  // Monitor / scoreboard. At a negedge, a handshake seen here completes at
  // the next posedge (edge number cyc+1).
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete(); e_q.delete();
      mic = 0; last_t3 = -1000; st_len = 0;
      st_prev = 0; mv_prev = 0; hold_prev = 0;
      fc_model = 16'd0;
    end else begin
      tests++;
      if (frame_cnt !== fc_model) begin
        fails++; $display("FAIL frame_cnt: got %h expected %h", frame_cnt, fc_model);
      end
      if (hold_prev) begin
        tests++;
        if (m_valid !== 1'b1 || m_re !== h_re || m_im !== h_im || m_bin !== h_bin || m_last !== h_last) begin
          fails++;
          $display("FAIL stall_stable: got v=%b re=%h im=%h k=%0d last=%b expected v=1 re=%h im=%h k=%0d last=%b",
                   m_valid, m_re, m_im, m_bin, m_last, h_re, h_im, h_bin, h_last);
        end
      end
      if (eng_start && !st_prev) begin
        tests++;
        if (e_q.size() == 0) begin
          fails++; $display("FAIL run_entry: got eng_start at edge %0d expected no run (no full frame)", cyc);
        end else begin
          e_edge = e_q.pop_front();
          want = (e_edge + 1 > last_t3) ? e_edge + 1 : last_t3;
          if (e_edge == last_t3) coinc_n++;
          else if (e_edge < last_t3) full_n++;
          if (cyc != want) begin
            fails++; $display("FAIL run_entry: got edge %0d expected edge %0d", cyc, want);
          end
        end
        run_r = cyc; st_len = 0;
      end
      if (eng_start) st_len++;
      if (!eng_start && st_prev) begin
        tests++;
        if (st_len != ENG_LAT) begin
          fails++; $display("FAIL start_len: got %0d expected %0d", st_len, ENG_LAT);
        end
      end
      if (m_valid && !mv_prev) begin
        tests++;
        if (cyc != run_r + ENG_LAT + 1 || mic != 4) begin
          fails++; $display("FAIL drain_entry: got edge %0d fill %0d expected edge %0d fill 4",
                            cyc, mic, run_r + ENG_LAT + 1);
        end
        mic = 0;
      end
      tests++;
      if (s_ready !== (mic != 4)) begin
        fails++; $display("FAIL s_ready: got %b expected %b", s_ready, mic != 4);
      end
      if (m_valid && m_ready) begin
        xfer_n++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL bin: got k=%0d re=%h with nothing expected", m_bin, m_re);
        end else begin
          b = exp_q.pop_front();
          if (m_re !== b.re || m_im !== b.im || m_bin !== b.k || m_last !== (b.k == 2'd3)) begin
            fails++;
            $display("FAIL bin: got k=%0d re=%h im=%h last=%b expected k=%0d re=%h im=%h last=%b",
                     m_bin, m_re, m_im, m_last, b.k, b.re, b.im, b.k == 2'd3);
          end
          if (b.k == 2'd3) begin
            fc_model = fc_model + 16'd1;
            last_t3  = cyc + 1;
          end
        end
      end
      if (s_valid && s_ready) begin
        acc_flag = 1'b1;
        if (mic < 4) part[mic] = s_data;
        mic++;
        if (mic == 4) begin
          for (int k = 0; k < 4; k++) exp_q.push_back(dft4(part[0], part[1], part[2], part[3], k));
          e_q.push_back(cyc + 1);
        end
      end
      hold_prev = m_valid && !m_ready;
      h_re = m_re; h_im = m_im; h_bin = m_bin; h_last = m_last;
      st_prev = eng_start; mv_prev = m_valid;
    end
  end

  task automatic driver();
    forever begin
      @(posedge clk); #1;
      if (acc_flag) begin
        void'(src_q.pop_front());
        acc_flag = 1'b0;
      end
      s_valid = (src_q.size() > 0) && (int'($urandom_range(0, 99)) < src_pct);
      s_data  = (src_q.size() > 0) ? src_q[0] : 16'h0;
      m_ready = !snk_hold && (int'($urandom_range(0, 99)) < snk_pct);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (n >= budget) begin
      fails++; $display("FAIL %s_timeout: got %0d cycles expected under %0d", name, n, budget);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (out_snap() !== RESET_SNAP) begin
      fails++; $display("FAIL reset_state: got %h expected %h", out_snap(), RESET_SNAP);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    src_pct = 100; snk_pct = 100;
    src_q.push_back(16'd1); src_q.push_back(16'd2);
    src_q.push_back(16'd3); src_q.push_back(16'd4);
    wait_drain("basic", 200);
    tests++;
    if (frame_cnt !== 16'd1) begin
      fails++; $display("FAIL basic_frame_cnt: got %0d expected 1", frame_cnt);
    end
  endtask

  task automatic test_backpressure();
    int f0 = full_n;
    int n = 0;
    snk_hold = 1'b1; src_pct = 100; snk_pct = 100;
    for (int i = 0; i < 8; i++) src_q.push_back(16'($urandom));
    while (!m_valid && n < 100) begin @(posedge clk); #1; n++; end
    tests++;
    if (n >= 100) begin
      fails++; $display("FAIL bp_wait: got no m_valid in %0d cycles expected m_valid", n);
    end
    repeat (10) @(posedge clk);
    #1;
    tests++;
    if (s_ready !== 1'b0 || m_valid !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL bp_full: got s_ready=%b m_valid=%b busy=%b expected 0 1 1", s_ready, m_valid, busy);
    end
    snk_hold = 1'b0;
    wait_drain("backpressure", 300);
    tests++;
    if (full_n != f0 + 1) begin
      fails++; $display("FAIL bp_direct_run: got %0d full-frame restarts expected %0d", full_n - f0, 1);
    end
  endtask

  task automatic test_coincident();
    int c0 = coinc_n;
    src_pct = 100; snk_pct = 100;
    for (int i = 0; i < 12; i++) src_q.push_back(16'($urandom));
    wait_drain("coincident", 300);
    tests++;
    if (coinc_n - c0 < 2) begin
      fails++; $display("FAIL coincident_seen: got %0d expected at least 2", coinc_n - c0);
    end
  endtask

  task automatic test_reset_run();
    int n = 0;
    src_pct = 100; snk_pct = 100;
    for (int i = 0; i < 4; i++) src_q.push_back(16'($urandom));
    while (!eng_start && n < 100) begin @(posedge clk); #1; n++; end
    tests++;
    if (n >= 100) begin
      fails++; $display("FAIL rr_wait: got no eng_start in %0d cycles expected eng_start", n);
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (out_snap() !== RESET_SNAP) begin
      fails++; $display("FAIL reset_in_run: got %h expected %h", out_snap(), RESET_SNAP);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) src_q.push_back(16'($urandom));
    wait_drain("reset_run", 200);
    tests++;
    if (frame_cnt !== 16'd1) begin
      fails++; $display("FAIL rr_frame_cnt: got %0d expected 1", frame_cnt);
    end
  endtask

  task automatic test_reset_drain();
    int n = 0;
    int x0 = xfer_n;
    src_pct = 100; snk_pct = 100;
    for (int i = 0; i < 4; i++) src_q.push_back(16'($urandom));
    while (xfer_n < x0 + 2 && n < 100) begin @(posedge clk); #1; n++; end
    tests++;
    if (n >= 100) begin
      fails++; $display("FAIL rd_wait: got %0d transfers expected 2", xfer_n - x0);
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (out_snap() !== RESET_SNAP) begin
      fails++; $display("FAIL reset_in_drain: got %h expected %h", out_snap(), RESET_SNAP);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) src_q.push_back(16'($urandom));
    wait_drain("reset_drain", 200);
    tests++;
    if (frame_cnt !== 16'd1) begin
      fails++; $display("FAIL rd_frame_cnt: got %0d expected 1", frame_cnt);
    end
  endtask

  task automatic test_wrap();
    @(posedge clk); #1;
    force dut.frame_cnt = 16'hFFFF;
    fc_model = 16'hFFFF;
    @(posedge clk); #1;
    release dut.frame_cnt;
    src_pct = 100; snk_pct = 100;
    for (int i = 0; i < 4; i++) src_q.push_back(16'($urandom));
    wait_drain("wrap0", 200);
    tests++;
    if (frame_cnt !== 16'd0) begin
      fails++; $display("FAIL wrap_zero: got %h expected 0000", frame_cnt);
    end
    for (int i = 0; i < 4; i++) src_q.push_back(16'($urandom));
    wait_drain("wrap1", 200);
    tests++;
    if (frame_cnt !== 16'd1) begin
      fails++; $display("FAIL wrap_one: got %h expected 0001", frame_cnt);
    end
  endtask

  task automatic test_random();
    logic [15:0] fc0 = frame_cnt;
    src_pct = 60; snk_pct = 55;
    for (int i = 0; i < 4000; i++) src_q.push_back(16'($urandom));
    wait_drain("random", 60000);
    tests++;
    if (frame_cnt !== 16'(fc0 + 16'd1000)) begin
      fails++; $display("FAIL random_frames: got %0d expected %0d", frame_cnt, 16'(fc0 + 16'd1000));
    end
  endtask

  initial begin
    fork
      driver();
    join_none
    test_reset();
    test_basic();
    test_backpressure();
    test_coincident();
    test_reset_run();
    test_reset_drain();
    test_wrap();
    test_random();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
